// File: rtl/bitstream_loader_if.sv
// bitstream_loader_if: valid/ready word stream carrying the bitstream into the loader
interface bitstream_loader_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] cfg_data;
  logic cfg_valid;
  logic cfg_ready;
  modport master (output cfg_data, cfg_valid, input cfg_ready);
  modport slave (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/bitstream_loader.sv
// bitstream_loader: serialises bitstream words into the connection then CLB scan chains
// Optional chain readback is enabled with `define LOADER_READBACK_EN
module bitstream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int CONN_CHAIN_LEN = 416,
  parameter int CLB_CHAIN_LEN = 72,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  bitstream_loader_if.slave cfg,
  output logic scan_clk,
  output logic conn_scan_in,
  output logic conn_scan_en,
  output logic clb_scan_in,
  output logic clb_scan_en,
  input  logic conn_scan_out,
  input  logic clb_scan_out,
  output logic busy,
  output logic done,
  output logic [DATA_WIDTH-1:0] readback_data,
  output logic readback_valid
);
  localparam int RW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD_CONN, LOAD_CLB, DONE} state_t;
  typedef enum logic [1:0] {WAIT, PH_L, PH_H} phase_t;
  state_t state;
  phase_t ph;
  logic [DATA_WIDTH-1:0] sr;
  logic [RW-1:0] rem;
  logic [CNT_WIDTH-1:0] cnt;
  logic conn, last, bit_next;
  assign conn = state == LOAD_CONN;
  assign last = cnt == (conn ? CNT_WIDTH'(CONN_CHAIN_LEN - 1) : CNT_WIDTH'(CLB_CHAIN_LEN - 1));
  assign bit_next = ph == WAIT ? sr[0] : sr[1];
  assign cfg.cfg_ready = busy && rem == '0;
`ifdef LOADER_READBACK_EN
  logic [DATA_WIDTH-1:0] rb_word, rb_mask;
  logic sample;
  assign sample = conn ? conn_scan_out : clb_scan_out;
`else
  logic unused_scan_out;
  assign unused_scan_out = conn_scan_out ^ clb_scan_out;
  assign readback_data = '0;
  assign readback_valid = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= WAIT;
      sr <= '0;
      rem <= '0;
      cnt <= '0;
      scan_clk <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
      clb_scan_in <= 1'b0;
      clb_scan_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef LOADER_READBACK_EN
      rb_word <= '0;
      rb_mask <= DATA_WIDTH'(1);
      readback_data <= '0;
      readback_valid <= 1'b0;
`endif
    end else begin
`ifdef LOADER_READBACK_EN
      readback_valid <= 1'b0;
`endif
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD_CONN;
          busy <= 1'b1;
          done <= 1'b0;
          conn_scan_en <= 1'b1;
        end
        default: begin
          if (cfg.cfg_valid && cfg.cfg_ready) begin
            sr <= cfg.cfg_data;
            rem <= RW'(DATA_WIDTH);
          end
          case (ph)
            WAIT: if (rem != '0) begin
              ph <= PH_L;
              if (conn) conn_scan_in <= bit_next;
              else clb_scan_in <= bit_next;
            end
            PH_L: begin
              ph <= PH_H;
              scan_clk <= 1'b1;
`ifdef LOADER_READBACK_EN
              rb_word <= rb_word | (sample ? rb_mask : '0);
              rb_mask <= rb_mask << 1;
`endif
            end
            default: begin
              scan_clk <= 1'b0;
`ifdef LOADER_READBACK_EN
              if (last || rb_mask == '0) begin
                readback_data <= rb_word;
                readback_valid <= 1'b1;
                rb_word <= '0;
                rb_mask <= DATA_WIDTH'(1);
              end
`endif
              if (last) begin
                // every chain starts on a fresh word, so leftover bits are dropped
                cnt <= '0;
                sr <= '0;
                rem <= '0;
                ph <= WAIT;
                conn_scan_in <= 1'b0;
                clb_scan_in <= 1'b0;
                conn_scan_en <= 1'b0;
                clb_scan_en <= conn;
                state <= conn ? LOAD_CLB : DONE;
                busy <= conn;
                done <= !conn;
              end else begin
                cnt <= cnt + CNT_WIDTH'(1);
                sr <= sr >> 1;
                rem <= rem - RW'(1);
                ph <= rem > RW'(1) ? PH_L : WAIT;
                if (rem > RW'(1)) begin
                  if (conn) conn_scan_in <= bit_next;
                  else clb_scan_in <= bit_next;
                end
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: doc/bitstream_loader.md
Name: bitstream_loader

Overview:
Configuration front end for the FPGA core. It accepts a bitstream as parallel words over a valid/ready handshake and serialises it into the core's two scan chains. The connection chain is loaded first, then the CLB chain. It generates scan_clk, drives the scan data and scan enables, and flags completion. It sits directly upstream of fpga_core, feeding conn_scan_in/conn_scan_en, clb_scan_in/clb_scan_en and scan_clk.

Parameters:
DATA_WIDTH, 8, width of one bitstream word; bits are consumed LSB first.
CONN_CHAIN_LEN, 416, total bits in the connection scan chain.
CLB_CHAIN_LEN, 72, total bits in the CLB scan chain.
CNT_WIDTH, 16, width of the bit counter; must satisfy 2^CNT_WIDTH > max(CONN_CHAIN_LEN, CLB_CHAIN_LEN).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
cfg_data  input  DATA_WIDTH  bitstream word.
cfg_valid  input  1  cfg_data is valid.
cfg_ready  output  1  loader can accept a word this cycle.
scan_clk  output  1  registered scan clock to the core, equal to clk/2 while shifting.
conn_scan_in  output  1  serial data to the connection chain.
conn_scan_en  output  1  connection chain shift enable.
clb_scan_in  output  1  serial data to the CLB chain.
clb_scan_en  output  1  CLB chain shift enable.
conn_scan_out  input  1  connection chain tail; used only with the readback feature.
clb_scan_out  input  1  CLB chain tail; used only with the readback feature.
busy  output  1  high in LOAD_CONN and LOAD_CLB.
done  output  1  high in DONE.
readback_data  output  DATA_WIDTH  captured chain output word (readback feature).
readback_valid  output  1  one-cycle strobe for readback_data.

Behaviour:
- Reset values: every output is 0, state is IDLE, shift register is empty, bit counter is 0.
- States: IDLE -> LOAD_CONN on start; LOAD_CONN -> LOAD_CLB after CONN_CHAIN_LEN bits; LOAD_CLB -> DONE after CLB_CHAIN_LEN bits; DONE -> LOAD_CONN on start.
- start is ignored while busy.
- Word buffer: one DATA_WIDTH shift register plus a remaining-bits count.
  - cfg_ready = busy && buffer empty.
  - A word is accepted when cfg_valid && cfg_ready.
  - The buffer becomes non-empty on the next cycle.
- Bit slot is two clk cycles:
  - Phase L: scan_clk=0. The active chain's scan_in is set to buffer[0] and its scan_en=1.
  - Phase H: scan_clk=1, so the core captures on this rising edge. Then the buffer shifts right and the bit counter increments.
- Throughput: one bit per 2 cycles. The first scan_clk rise occurs no earlier than 2 cycles after the first word is accepted.
- Starvation: if the buffer is empty in phase L, scan_clk stays 0 and no edge is produced. scan_en and scan_in hold their values.
- The active chain's scan_en stays high for the whole chain, starvation included. The inactive chain's scan_en and scan_in are 0.
- Chain boundary: each chain starts on a fresh word. Unused high bits of the last word of a chain are discarded and the buffer is emptied.
- Total words required per load = ceil(CONN_CHAIN_LEN/DATA_WIDTH) + ceil(CLB_CHAIN_LEN/DATA_WIDTH).
- On the last bit of a chain:
  - That chain's scan_en drops in the cycle after its final phase H.
  - The bit counter resets to 0.
- Entering DONE: scan_clk=0, both scan_en=0, cfg_ready=0. done stays high until start.
- Reset mid-load: the state returns to IDLE on the next edge. All outputs go to 0, the buffer is cleared, and a partial chain is not resumed.
- Simultaneous start and reset: reset wins.

Optional Feature:
Macro: LOADER_READBACK_EN.
- Defined:
  - On each phase H, the active chain's scan_out is sampled before the edge takes effect. Samples are packed LSB first into readback_data.
  - readback_valid pulses for one cycle per DATA_WIDTH samples.
  - At chain end, a partial word is flushed with its upper bits zero.
  - The readback word count per chain equals the load word count.
- Undefined: readback_data=0 and readback_valid=0 permanently, and scan_out inputs are unused.

Test Plan:
Test parameters: DATA_WIDTH=4, CONN_CHAIN_LEN=6, CLB_CHAIN_LEN=5.
- Basic load: reset, start, then words 4'hA, 4'h3, 4'h5, 4'h1 with cfg_valid held.
  - conn_scan_in at the scan_clk rises is 0,1,0,1,1,1.
  - clb_scan_in is 1,0,1,0,1.
  - Exactly 11 scan_clk rises; done=1; conn_scan_en high for 6 rises only.
- Starvation: deliver 4'hA, wait 20 cycles, then the remaining words.
  - No scan_clk edges during the wait; conn_scan_en stays 1; the final bit stream matches the basic load.
- Reset mid-load: assert reset after the 3rd scan_clk rise.
  - Next cycle: all outputs 0. A new start and full load completes correctly with 11 rises.
- Start while busy: pulse start during LOAD_CLB.
  - Ignored; the load completes normally with done=1.
- Readback (LOADER_READBACK_EN), with a testbench model returning conn_scan_out=1 and clb_scan_out=0.
  - readback words 4'hF, 4'h3, then 4'h0, 4'h0, each with a one-cycle readback_valid.
- Reload from DONE: start again and feed 4 words.
  - done falls the cycle after start; the second load is identical to the first.
